// File: rtl/game_pio_bank.sv
// Avalon-MM bank of NUM_OUT output channels (level or one-cycle strobe) and
// NUM_IN synchronised input lines with rising-edge capture and maskable irq.
module game_pio_bank #(
    parameter int                   NUM_OUT    = 4,
    parameter int                   DATA_W     = 32,
    parameter int                   NUM_IN     = 2,
    parameter logic [NUM_OUT-1:0]   PULSE_MASK = '0
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset,
    input  logic [3:0]                address,
    input  logic                      chipselect,
    input  logic                      write,
    input  logic                      read,
    input  logic [DATA_W-1:0]         writedata,
    output logic [DATA_W-1:0]         readdata,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    input  logic [NUM_IN-1:0]         in_raw,
    output logic                      irq
);

    localparam logic [3:0] ADDR_SYNC   = 4'd8;
    localparam logic [3:0] ADDR_EDGE   = 4'd9;
    localparam logic [3:0] ADDR_MASK   = 4'd10;
    localparam logic [3:0] ADDR_STROBE = 4'd11;

    logic [DATA_W-1:0]  chan [NUM_OUT];
    logic [NUM_IN-1:0]  sync_meta, sync, sync_d;
    logic [NUM_IN-1:0]  edge_cap, irq_mask;
    logic [NUM_IN-1:0]  rise, edge_clr, edge_cap_next, irq_mask_next;
    logic [NUM_OUT-1:0] strobe_status;
    logic [DATA_W-1:0]  rd_mux;
    logic               wr_en, rd_en;

    assign wr_en = chipselect & write;
    assign rd_en = chipselect & read;

    // Output channels. Strobe channels fall back to 0 unless rewritten, so
    // back-to-back writes give contiguous one-cycle values.
    // NOTE: the channel array is a handful of output flops, not a RAM, so it
    // is reset like any other register; sequential state always uses <=.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int k = 0; k < NUM_OUT; k++) chan[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (wr_en && address == 4'(k))
                    chan[k] <= writedata;
                else if (PULSE_MASK[k])
                    chan[k] <= '0;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        out_data      = '0;
        strobe_status = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            out_data[k*DATA_W +: DATA_W] = chan[k];
            strobe_status[k]             = PULSE_MASK[k] & (|chan[k]);
        end
    end

    // Input path: two-flop synchroniser, one delay flop for edge detection.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync_meta <= '0;
            sync      <= '0;
            sync_d    <= '0;
        end else begin
            sync_meta <= in_raw;
            sync      <= sync_meta;
            sync_d    <= sync;
        end
    end

    assign rise = sync & ~sync_d;

    always_comb begin
        edge_clr      = '0;
        irq_mask_next = irq_mask;
        if (wr_en && address == ADDR_EDGE) edge_clr      = writedata[NUM_IN-1:0];
        if (wr_en && address == ADDR_MASK) irq_mask_next = writedata[NUM_IN-1:0];
        // A capture in the same cycle as its clear must survive.
        edge_cap_next = (edge_cap & ~edge_clr) | rise;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            edge_cap <= '0;
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            edge_cap <= edge_cap_next;
            irq_mask <= irq_mask_next;
            irq      <= |(edge_cap_next & irq_mask_next);
        end
    end

    // Read mux sees pre-write state, so a same-cycle read/write returns old data.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_SYNC:   rd_mux[NUM_IN-1:0]  = sync;
            ADDR_EDGE:   rd_mux[NUM_IN-1:0]  = edge_cap;
            ADDR_MASK:   rd_mux[NUM_IN-1:0]  = irq_mask;
            ADDR_STROBE: rd_mux[NUM_OUT-1:0] = strobe_status;
            default: begin
                for (int k = 0; k < NUM_OUT; k++)
                    if (address == 4'(k)) rd_mux = chan[k];
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)
            readdata <= '0;
        else if (rd_en)
            readdata <= rd_mux;
    end

endmodule

// File: tb/tb_game_pio_bank.sv
// Scoreboard bench for game_pio_bank: reads push expected data, a negedge
// monitor pops and compares one cycle after the read is sampled.
module tb_game_pio_bank;

    localparam int NUM_OUT = 4;
    localparam int DATA_W  = 32;
    localparam int NUM_IN  = 2;

    logic                      clk_clk = 1'b0;
    logic                      reset_reset;
    logic [3:0]                address;
    logic                      chipselect, write, read;
    logic [DATA_W-1:0]         writedata;
    logic [DATA_W-1:0]         readdata;
    logic [NUM_OUT*DATA_W-1:0] out_data;
    logic [NUM_IN-1:0]         in_raw;
    logic                      irq;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic        rd_seen = 1'b0;

    game_pio_bank #(
        .NUM_OUT(NUM_OUT), .DATA_W(DATA_W), .NUM_IN(NUM_IN), .PULSE_MASK(4'b1000)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .address(address),
        .chipselect(chipselect), .write(write), .read(read),
        .writedata(writedata), .readdata(readdata), .out_data(out_data),
        .in_raw(in_raw), .irq(irq)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Read scoreboard: compare at the negedge after the sampling edge.
    always @(posedge clk_clk) rd_seen <= chipselect && read && !reset_reset;

    always @(negedge clk_clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0)
                check("rd_unexpected", 32'd1, 32'd0);
            else
                check(tag_q.pop_front(), readdata, exp_q.pop_front());
        end
    end

    task automatic idle();
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
    endtask

    // Bus tasks are entered at a negedge and return at the next negedge.
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
        @(negedge clk_clk);
        idle();
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        chipselect = 1'b1; write = 1'b0; read = 1'b1; address = a;
        @(negedge clk_clk);
        idle();
    endtask

    task automatic bus_rw(input logic [3:0] a, input logic [31:0] d, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        chipselect = 1'b1; write = 1'b1; read = 1'b1; address = a; writedata = d;
        @(negedge clk_clk);
        idle();
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] addrs [9];
        addrs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11, 4'd15};

        reset_reset = 1'b1;
        idle();
        address   = '0;
        writedata = '0;
        in_raw    = '0;
        step(3);
        reset_reset = 1'b0;
        step(1);

        // 1: reset state
        check("rst_out_data", {31'd0, |out_data}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_readdata", readdata, 32'd0);
        foreach (addrs[i]) bus_read(addrs[i], 32'd0, $sformatf("rst_rd_a%0d", addrs[i]));

        // 2: level channel, unmapped address, same-cycle read/write
        bus_write(4'd1, 32'h0000_1234);
        check("lvl_out1", out_data[63:32], 32'h0000_1234);
        step(2);
        check("lvl_out1_hold", out_data[63:32], 32'h0000_1234);
        bus_read(4'd1, 32'h0000_1234, "lvl_rd1");
        bus_write(4'd5, 32'hDEAD_BEEF);
        bus_read(4'd5, 32'd0, "unmapped_rd5");
        bus_rw(4'd0, 32'h0000_00AA, 32'd0, "rw_same_old");
        bus_read(4'd0, 32'h0000_00AA, "rw_same_new");
        check("lvl_out0", out_data[31:0], 32'h0000_00AA);

        // 3: strobe channel 3, back-to-back then idle
        bus_write(4'd3, 32'd1);
        check("stb_cyc1", out_data[127:96], 32'd1);
        bus_write(4'd3, 32'd1);
        check("stb_cyc2", out_data[127:96], 32'd1);
        step(1);
        check("stb_cleared", out_data[127:96], 32'd0);
        bus_write(4'd3, 32'h0000_0077);
        bus_read(4'd11, 32'h0000_0008, "stb_status_on");
        bus_read(4'd11, 32'd0, "stb_status_off");
        bus_read(4'd3, 32'd0, "stb_rd3");

        // 4: capture on in_raw[0], irq, W1C
        bus_write(4'd10, 32'h1);
        step(2);
        check("irq_pre", {31'd0, irq}, 32'd0);
        in_raw[0] = 1'b1;
        step(1);
        bus_read(4'd9, 32'd0, "cap_edge2");
        in_raw[0] = 1'b0;
        bus_read(4'd9, 32'd0, "cap_edge3_pre");
        bus_read(4'd9, 32'h1, "cap_set");
        check("irq_set", {31'd0, irq}, 32'd1);
        bus_write(4'd9, 32'h1);
        step(1);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        bus_read(4'd9, 32'd0, "cap_w1c");

        // 5: set beats same-cycle clear; unmask asserts irq
        in_raw[1] = 1'b1;
        step(2);
        bus_write(4'd9, 32'h2);
        bus_read(4'd9, 32'h2, "set_wins");
        bus_read(4'd8, 32'h2, "sync_rd");
        check("irq_masked", {31'd0, irq}, 32'd0);
        bus_write(4'd10, 32'h2);
        step(1);
        check("irq_unmask", {31'd0, irq}, 32'd1);
        bus_read(4'd10, 32'h2, "mask_rd");

        // 6: asynchronous reset mid-strobe with a live capture
        in_raw = '0;
        bus_read(4'd1, 32'h0000_1234, "pre_rst_rd");
        bus_write(4'd3, 32'h5);
        check("stb_before_rst", out_data[127:96], 32'h5);
        #1;
        reset_reset = 1'b1;
        #1;
        check("arst_out_data", {31'd0, |out_data}, 32'd0);
        check("arst_irq", {31'd0, irq}, 32'd0);
        check("arst_readdata", readdata, 32'd0);
        step(2);
        reset_reset = 1'b0;
        step(1);
        bus_read(4'd9, 32'd0, "arst_edge_cap");
        bus_read(4'd10, 32'd0, "arst_mask");
        bus_read(4'd1, 32'd0, "arst_chan1");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) step(1);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
